// File: rtl/serial_slice_adder.sv
// Slice-serial add/subtract unit: processes one SLICE-bit slice per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.

module serial_slice_adder_chk #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic             IN_READY,
  input  logic             OUT_VALID,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  input  logic             SUB,
  input  logic [WIDTH-1:0] Y,
  input  logic             C_OUT,
  input  logic             V_OUT,
  input  logic             Z_OUT
);
  logic [WIDTH-1:0] cap_a_r;
  logic [WIDTH-1:0] cap_b_r;
  logic             cap_c_r;
  logic [WIDTH:0]   exp_s;

  assign exp_s = {1'b0, cap_a_r} + {1'b0, cap_b_r} + {{WIDTH{1'b0}}, cap_c_r};

  // Capture accepted operands and check the presented result against them
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_a_r <= '0;
      cap_b_r <= '0;
      cap_c_r <= 1'b0;
    end else begin
      if (IN_VALID && IN_READY) begin
        cap_a_r <= A;
        cap_b_r <= SUB ? ~B : B;
        cap_c_r <= C_IN;
      end
      if (OUT_VALID) begin
        assert ({C_OUT, Y} == exp_s);
        assert (Z_OUT == (Y == '0));
        assert (V_OUT == ((cap_a_r[WIDTH-1] == cap_b_r[WIDTH-1]) && (Y[WIDTH-1] != cap_a_r[WIDTH-1])));
      end
      assert (!(OUT_VALID && IN_READY));
    end
  end
endmodule

module serial_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             C_OUT,
  output logic             V_OUT,
  output logic             Z_OUT
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] beff_r;
  logic [WIDTH-1:0] y_r;
  logic             c_out_r;
  logic             v_out_r;
  logic             z_out_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [SLICE:0]   slice_sum_s;
  logic [WIDTH-1:0] y_next_s;

  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    slice_add = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  endfunction

  // Current slice sum and the result word with that slice merged in
  always_comb begin
    slice_sum_s = slice_add(a_r[cnt_r*SLICE +: SLICE], beff_r[cnt_r*SLICE +: SLICE], carry_r);
    y_next_s    = y_r;
    y_next_s[cnt_r*SLICE +: SLICE] = slice_sum_s[SLICE-1:0];
  end

  // Handshake FSM, slice sequencing and registered result/flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      beff_r      <= '0;
      y_r         <= '0;
      c_out_r     <= 1'b0;
      v_out_r     <= 1'b0;
      z_out_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (IN_VALID && in_ready_r) begin
            a_r        <= A;
            beff_r     <= SUB ? ~B : B;
            carry_r    <= C_IN;
            cnt_r      <= '0;
            y_r        <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          y_r     <= y_next_s;
          carry_r <= slice_sum_s[SLICE];
          cnt_r   <= cnt_r + CNT_W'(1);
          // Flags come from the merged word so they are valid the same edge OUT_VALID rises
          if (cnt_r == LAST_SLICE) begin
            c_out_r     <= slice_sum_s[SLICE];
            v_out_r     <= (a_r[WIDTH-1] == beff_r[WIDTH-1]) && (y_next_s[WIDTH-1] != a_r[WIDTH-1]);
            z_out_r     <= (y_next_s == '0);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are forced low for as long as reset is held
  assign IN_READY  = in_ready_r & ~RST;
  assign OUT_VALID = out_valid_r & ~RST;
  assign Y         = y_r;
  assign C_OUT     = c_out_r;
  assign V_OUT     = v_out_r;
  assign Z_OUT     = z_out_r;

  serial_slice_adder_chk #(.WIDTH(WIDTH)) u_chk (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_VALID (OUT_VALID),
    .A         (A),
    .B         (B),
    .C_IN      (C_IN),
    .SUB       (SUB),
    .Y         (Y),
    .C_OUT     (C_OUT),
    .V_OUT     (V_OUT),
    .Z_OUT     (Z_OUT)
  );
endmodule

// File: tb/tb_serial_slice_adder.sv
// Bench for serial_slice_adder: three configurations (32/8, 12/4, 8/8) checked against
// directed vectors, an arithmetic reference model and hand-written handshake/reset sequences.

module tb_serial_slice_adder;
  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  in_valid_s;
  logic [31:0] a_s, b_s;
  logic        c_in_s, sub_s, out_ready_s;

  logic        ir32, ov32, c32, v32, z32;
  logic [31:0] y32;
  logic        ir12, ov12, c12, v12, z12;
  logic [11:0] y12;
  logic        ir8, ov8, c8, v8, z8;
  logic [7:0]  y8;

  int          sel;
  int          checks = 0;
  int          failures = 0;
  logic        cur_ir, cur_ov, cur_c, cur_v, cur_z;
  logic [31:0] cur_y;
  int          wid[3] = '{32, 12, 8};
  int          nsl[3] = '{4, 3, 1};

  always #5 CLK = ~CLK;

  serial_slice_adder #(.WIDTH(32), .SLICE(8)) u_dut32 (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid_s[0]), .IN_READY(ir32), .A(a_s), .B(b_s),
    .C_IN(c_in_s), .SUB(sub_s), .OUT_VALID(ov32), .OUT_READY(out_ready_s), .Y(y32),
    .C_OUT(c32), .V_OUT(v32), .Z_OUT(z32));

  serial_slice_adder #(.WIDTH(12), .SLICE(4)) u_dut12 (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid_s[1]), .IN_READY(ir12), .A(a_s[11:0]), .B(b_s[11:0]),
    .C_IN(c_in_s), .SUB(sub_s), .OUT_VALID(ov12), .OUT_READY(out_ready_s), .Y(y12),
    .C_OUT(c12), .V_OUT(v12), .Z_OUT(z12));

  serial_slice_adder #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid_s[2]), .IN_READY(ir8), .A(a_s[7:0]), .B(b_s[7:0]),
    .C_IN(c_in_s), .SUB(sub_s), .OUT_VALID(ov8), .OUT_READY(out_ready_s), .Y(y8),
    .C_OUT(c8), .V_OUT(v8), .Z_OUT(z8));

  // View of whichever instance is under test
  always_comb begin
    cur_ir = ir32; cur_ov = ov32; cur_c = c32; cur_v = v32; cur_z = z32; cur_y = y32;
    case (sel)
      1: begin cur_ir = ir12; cur_ov = ov12; cur_c = c12; cur_v = v12; cur_z = z12; cur_y = {20'd0, y12}; end
      2: begin cur_ir = ir8;  cur_ov = ov8;  cur_c = c8;  cur_v = v8;  cur_z = z8;  cur_y = {24'd0, y8};  end
      default: ;
    endcase
  end

  typedef struct {
    int          s;
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] y;
    logic        c, v, z;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular and signed arithmetic on the operand values
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub, output logic [31:0] y,
                                output logic c, output logic v, output logic z);
    longint one, mask, half, ua, ub, full, sa, sb, ss;
    one  = 1;
    mask = (one << w) - 1;
    half = one << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(sub ? ~b : b) & mask;
    full = ua + ub + longint'(cin);
    sa   = (ua >= half) ? ua - (one << w) : ua;
    sb   = (ub >= half) ? ub - (one << w) : ub;
    ss   = sa + sb + longint'(cin);
    y    = 32'(full & mask);
    c    = ((full >> w) & one) != 0;
    v    = (ss >= half) || (ss < -half);
    z    = (full & mask) == 0;
  endfunction

  task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    int n = 0;
    while (!cur_ir && n < 20) begin @(negedge CLK); n++; end
    check({name, "/in_ready"}, 64'(cur_ir), 64'd1);
    a_s = a; b_s = b; c_in_s = cin; sub_s = sub;
    in_valid_s = 3'(3'b001 << sel);
    @(posedge CLK);
    @(negedge CLK);
    in_valid_s = 3'b000;
    a_s = $urandom; b_s = $urandom; c_in_s = 1'($urandom); sub_s = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!cur_ov && lat < 40) begin @(posedge CLK); @(negedge CLK); lat++; end
  endtask

  task automatic release_op(input string name);
    out_ready_s = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready_s = 1'b0;
    check({name, "/ov_after"}, 64'(cur_ov), 64'd0);
    check({name, "/ir_after"}, 64'(cur_ir), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] ey,
                        input logic ec, input logic ev, input logic ez, input int hold);
    int lat;
    start_op(name, a, b, cin, sub);
    wait_valid(lat);
    check({name, "/latency"}, 64'(lat), 64'(nsl[sel]));
    check({name, "/y"}, 64'(cur_y), 64'(ey));
    check({name, "/cvz"}, 64'({cur_c, cur_v, cur_z}), 64'({ec, ev, ez}));
    if (hold > 0) begin
      repeat (hold) @(negedge CLK);
      check({name, "/y_held"}, 64'({cur_ov, cur_y}), 64'({1'b1, ey}));
    end
    release_op(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] ey, ra, rb;
    logic        ec, ev, ez, rc, rs, ov_seen;
    int          lat;

    vecs[0] = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{0, 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{0, 32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1, 32'h00000ABC, 32'h00000544, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2, 32'h00000080, 32'h00000080, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

    sel = 0; RST = 1'b1; in_valid_s = 3'b000; out_ready_s = 1'b0;
    a_s = '0; b_s = '0; c_in_s = 1'b0; sub_s = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset/handshake", 64'({ir32, ov32, ir12, ov12, ir8, ov8}), 64'd0);
    check("reset/y_flags", 64'({y32, c32, v32, z32}), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("reset/ir_release", 64'({ir32, ir12, ir8}), 64'b111);

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].s;
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].y, vecs[i].c, vecs[i].v, vecs[i].z, i % 2);
    end

    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 12; i++) begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
        if (i == 0) begin ra = 32'hFFFFFFFF; rb = 32'hFFFFFFFF; end
        model(wid[s], ra, rb, rc, rs, ey, ec, ev, ez);
        run_op($sformatf("rnd%0d_%0d", s, i), ra, rb, rc, rs, ey, ec, ev, ez, $urandom_range(0, 3));
      end
    end

    // Backpressure: result must hold while the source keeps wiggling
    sel = 0;
    model(32, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, ey, ec, ev, ez);
    start_op("bp", 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    wait_valid(lat);
    check("bp/latency", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      a_s = $urandom; b_s = $urandom;
      in_valid_s = (i % 2 == 0) ? 3'b001 : 3'b000;
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("bp/hold%0d", i), 64'({cur_ov, cur_ir, cur_c, cur_v, cur_z, cur_y}),
            64'({1'b1, 1'b0, ec, ev, ez, ey}));
    end
    in_valid_s = 3'b000;
    release_op("bp");

    // Reset after two slices: operation dropped, no result ever shown
    start_op("rst", 32'h11223344, 32'h55667788, 1'b0, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst/outputs", 64'({cur_ov, cur_ir, cur_c, cur_v, cur_z, cur_y}), 64'd0);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("rst/ir_release", 64'(cur_ir), 64'd1);
    ov_seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (cur_ov) ov_seen = 1'b1;
    end
    check("rst/no_ov", 64'(ov_seen), 64'd0);
    run_op("rst_next", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
